// File: rtl/complex_mult_master.sv
// complex_mult_master
//   Sequences a complex dot product through an external complex multiplier:
//   it takes one operand pair per upstream handshake and hands it to the
//   multiplier. It then waits for the product, sign-extends the product and
//   adds it into the running real/imaginary accumulators. After len pairs it
//   presents the sum downstream. At most one multiplier transaction is in
//   flight at any time.
//
// Parameters
//   CNT_W  width of the job length and the element counter
//   ACC_W  width of each signed accumulator component (>= 17)
//
// Configuration
//   COMPLEX_MULT_MASTER_SAT_EN  defined: each accumulate saturates per
//                               component; undefined: accumulate wraps
//                               modulo 2^ACC_W.
//
// Ports
//   clk, rstn (async, active-low), sw_rst (sync clear, same effect as rstn)
//   start, len                   job request, sampled only in IDLE
//   busy                         high whenever not IDLE
//   in_val/in_rdy, in_a_*/in_b_* upstream operand pair
//   mul_op_val/mul_op_rdy, mul_op_1_*/mul_op_2_*  operands to multiplier
//   mul_res_val/mul_res_rdy, mul_res_re/im        product from multiplier
//   acc_val/acc_rdy, acc_re/acc_im                final dot-product result
module complex_mult_master #(
  parameter int CNT_W = 4,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [7:0]       in_a_re,
  input  logic [7:0]       in_a_im,
  input  logic [7:0]       in_b_re,
  input  logic [7:0]       in_b_im,
  output logic             mul_op_val,
  input  logic             mul_op_rdy,
  output logic [7:0]       mul_op_1_re,
  output logic [7:0]       mul_op_1_im,
  output logic [7:0]       mul_op_2_re,
  output logic [7:0]       mul_op_2_im,
  input  logic             mul_res_val,
  output logic             mul_res_rdy,
  input  logic [15:0]      mul_res_re,
  input  logic [15:0]      mul_res_im,
  output logic             acc_val,
  input  logic             acc_rdy,
  output logic [ACC_W-1:0] acc_re,
  output logic [ACC_W-1:0] acc_im
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [ACC_W-1:0] sum_re;
  logic [ACC_W-1:0] sum_im;

  // One extra bit keeps the compare exact when len is the maximum count.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  // Add a 16-bit two's-complement product into an accumulator component.
  // The sum is formed one bit wider so overflow is visible as a mismatch of
  // the top two bits.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0]      r);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-15){r[15]}}, r};
`ifdef COMPLEX_MULT_MASTER_SAT_EN
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  always_comb begin
    sum_re = acc_add(acc_re, mul_res_re);
    sum_im = acc_add(acc_im, mul_res_im);
  end

  // Handshake outputs are registered and updated together with the state
  // so each one is high exactly while the FSM is in its state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      mul_op_1_re <= '0;
      mul_op_1_im <= '0;
      mul_op_2_re <= '0;
      mul_op_2_im <= '0;
      busy        <= 1'b0;
      in_rdy      <= 1'b0;
      mul_op_val  <= 1'b0;
      mul_res_rdy <= 1'b0;
      acc_val     <= 1'b0;
    end else if (sw_rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      mul_op_1_re <= '0;
      mul_op_1_im <= '0;
      mul_op_2_re <= '0;
      mul_op_2_im <= '0;
      busy        <= 1'b0;
      in_rdy      <= 1'b0;
      mul_op_val  <= 1'b0;
      mul_res_rdy <= 1'b0;
      acc_val     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
            len_q  <= len;
            busy   <= 1'b1;
            if (len == '0) begin
              state   <= S_DONE;
              acc_val <= 1'b1;
            end else begin
              state  <= S_LOAD;
              in_rdy <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_val) begin
            mul_op_1_re <= in_a_re;
            mul_op_1_im <= in_a_im;
            mul_op_2_re <= in_b_re;
            mul_op_2_im <= in_b_im;
            in_rdy      <= 1'b0;
            mul_op_val  <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mul_op_rdy) begin
            mul_op_val  <= 1'b0;
            mul_res_rdy <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mul_res_val) begin
            acc_re      <= sum_re;
            acc_im      <= sum_im;
            cnt         <= cnt_inc[CNT_W-1:0];
            mul_res_rdy <= 1'b0;
            if (cnt_inc == {1'b0, len_q}) begin
              acc_val <= 1'b1;
              state   <= S_DONE;
            end else begin
              in_rdy <= 1'b1;
              state  <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          if (acc_rdy) begin
            acc_val <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          in_rdy      <= 1'b0;
          mul_op_val  <= 1'b0;
          mul_res_rdy <= 1'b0;
          acc_val     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mult_master.sv
// Self-checking bench for complex_mult_master (ACC_W = 17, CNT_W = 4).
// The bench plays the upstream source, the multiplier and the downstream
// sink. The expected sums come from plain integer arithmetic on the
// products, with wrap or saturation chosen by COMPLEX_MULT_MASTER_SAT_EN.
module tb_complex_mult_master;
  localparam int CNT_W = 4;
  localparam int ACC_W = 17;

  logic             clk = 1'b0;
  logic             rstn;
  logic             sw_rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             in_val;
  logic             in_rdy;
  logic [7:0]       in_a_re, in_a_im, in_b_re, in_b_im;
  logic             mul_op_val;
  logic             mul_op_rdy;
  logic [7:0]       mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im;
  logic             mul_res_val;
  logic             mul_res_rdy;
  logic [15:0]      mul_res_re, mul_res_im;
  logic             acc_val;
  logic             acc_rdy;
  logic [ACC_W-1:0] acc_re, acc_im;

  always #5 clk = ~clk;

  complex_mult_master #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .start(start), .len(len),
    .busy(busy), .in_val(in_val), .in_rdy(in_rdy),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .mul_op_val(mul_op_val), .mul_op_rdy(mul_op_rdy),
    .mul_op_1_re(mul_op_1_re), .mul_op_1_im(mul_op_1_im),
    .mul_op_2_re(mul_op_2_re), .mul_op_2_im(mul_op_2_im),
    .mul_res_val(mul_res_val), .mul_res_rdy(mul_res_rdy),
    .mul_res_re(mul_res_re), .mul_res_im(mul_res_im),
    .acc_val(acc_val), .acc_rdy(acc_rdy), .acc_re(acc_re), .acc_im(acc_im)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Handshake activity counters.
  int op_hs = 0;
  int in_rdy_cycles = 0;
  always @(posedge clk) begin
    if (mul_op_val && mul_op_rdy) op_hs <= op_hs + 1;
    if (in_rdy) in_rdy_cycles <= in_rdy_cycles + 1;
  end

  function automatic longint sx(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference accumulate: exact integer sum, then wrap or clamp to ACC_W.
  function automatic longint model_add(input longint acc, input longint r);
    longint s, hi, lo, m;
    m  = longint'(1) << ACC_W;
    hi = (m >> 1) - 1;
    lo = -(m >> 1);
    s  = acc + r;
`ifdef COMPLEX_MULT_MASTER_SAT_EN
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`else
    s = s & (m - 1);
    if (s > hi) s = s - m;
`endif
    return s;
  endfunction

  function automatic bit sig(input int w);
    case (w)
      0: return in_rdy;
      1: return mul_res_rdy;
      2: return acc_val;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string tag);
    int n = 0;
    while (!sig(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sig(w)) check({tag, "_timeout"}, 0, 1);
  endtask

  // Job options set before calling run_job.
  bit     fix_ops   = 0;
  bit     force_res = 0;
  longint frc_re, frc_im;
  int     issue_hold = -1;
  longint last_re, last_im;

  task automatic run_job(input int n, input int abort_pair, input string tag);
    longint er = 0, ei = 0;
    int base_op, p, hold, lat;
    logic [7:0] ar, ai, br, bi;
    logic [31:0] ops;
    longint pr, pi;
    logic [15:0] rr, ri;
    base_op = op_hs;
    @(negedge clk);
    start = 1'b1;
    len = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    for (p = 0; p < n; p++) begin
      if (fix_ops) begin
        ar = 8'd1; ai = 8'd2; br = 8'd3; bi = 8'd4;
      end else begin
        ar = 8'($urandom); ai = 8'($urandom); br = 8'($urandom); bi = 8'($urandom);
      end
      in_a_re = ar; in_a_im = ai; in_b_re = br; in_b_im = bi;
      in_val = 1'b1;
      // Hold a spurious start while busy; it must have no effect.
      start = 1'($urandom_range(0, 1));
      wait_for(0, {tag, "_in"});
      @(negedge clk);
      in_val = 1'b0;
      start = 1'b0;
      in_a_re = 8'($urandom);
      check({tag, "_opval"}, longint'(mul_op_val), 1);
      ops = {mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im};
      check({tag, "_ops"}, longint'(ops), longint'({ar, ai, br, bi}));
      hold = (issue_hold >= 0) ? issue_hold : int'($urandom_range(0, 2));
      repeat (hold) begin
        @(negedge clk);
        check({tag, "_hold_val"}, longint'(mul_op_val), 1);
        check({tag, "_hold_ops"},
              longint'({mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im}),
              longint'({ar, ai, br, bi}));
        check({tag, "_hold_inrdy"}, longint'(in_rdy), 0);
      end
      mul_op_rdy = 1'b1;
      @(negedge clk);
      mul_op_rdy = 1'b0;
      check({tag, "_resrdy"}, longint'(mul_res_rdy), 1);
      if (p == abort_pair) begin
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        return;
      end
      if (force_res) begin
        pr = frc_re; pi = frc_im;
      end else begin
        pr = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
        pi = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
      end
      rr = pr[15:0];
      ri = pi[15:0];
      lat = int'($urandom_range(0, 3));
      repeat (lat) @(negedge clk);
      mul_res_re = rr; mul_res_im = ri; mul_res_val = 1'b1;
      wait_for(1, {tag, "_res"});
      @(negedge clk);
      mul_res_val = 1'b0;
      mul_res_re = 16'($urandom);
      er = model_add(er, longint'($signed(rr)));
      ei = model_add(ei, longint'($signed(ri)));
    end
    wait_for(2, {tag, "_done"});
    check({tag, "_acc_re"}, sx(acc_re), er);
    check({tag, "_acc_im"}, sx(acc_im), ei);
    check({tag, "_nops"}, longint'(op_hs - base_op), longint'(n));
    repeat (int'($urandom_range(0, 3))) begin
      @(negedge clk);
      check({tag, "_acc_hold"}, longint'(acc_val), 1);
      check({tag, "_acc_stable"}, sx(acc_re), er);
    end
    last_re = sx(acc_re);
    last_im = sx(acc_im);
    // Start in the same cycle as the result handshake must be ignored.
    acc_rdy = 1'b1;
    start = 1'b1;
    len = CNT_W'(3);
    @(negedge clk);
    acc_rdy = 1'b0;
    start = 1'b0;
    check({tag, "_idle_busy"}, longint'(busy), 0);
    check({tag, "_idle_accval"}, longint'(acc_val), 0);
  endtask

  initial begin
    int base_in;
    rstn = 1'b0; sw_rst = 1'b0; start = 1'b0; len = '0;
    in_val = 1'b0; in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    mul_op_rdy = 1'b0; mul_res_val = 1'b0; mul_res_re = '0; mul_res_im = '0;
    acc_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_rdy", longint'(in_rdy), 0);
    check("rst_op_val", longint'(mul_op_val), 0);
    check("rst_res_rdy", longint'(mul_res_rdy), 0);
    check("rst_acc_val", longint'(acc_val), 0);
    check("rst_acc", sx(acc_re) | sx(acc_im), 0);
    check("rst_ops", longint'({mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im}), 0);
    rstn = 1'b1;

    // (1+2j)(3+4j) = -5+10j
    fix_ops = 1;
    run_job(1, -1, "single");
    check("single_re_const", last_re, -5);
    check("single_im_const", last_im, 10);
    fix_ops = 0;

    force_res = 1; frc_re = 100; frc_im = -50;
    run_job(3, -1, "three");
    check("three_re_const", last_re, 300);
    check("three_im_const", last_im, -150);

    frc_re = 32767; frc_im = 32767;
    run_job(3, -1, "ovf");
`ifdef COMPLEX_MULT_MASTER_SAT_EN
    check("ovf_sat_const", last_re, 65535);
`else
    check("ovf_wrap_const", last_re, -32771);
`endif
    force_res = 0;

    // Zero-length job.
    base_in = in_rdy_cycles;
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", longint'(busy), 1);
    check("len0_accval", longint'(acc_val), 1);
    check("len0_acc", sx(acc_re) | sx(acc_im), 0);
    check("len0_opval", longint'(mul_op_val), 0);
    acc_rdy = 1'b1;
    @(negedge clk);
    acc_rdy = 1'b0;
    check("len0_inrdy", longint'(in_rdy_cycles - base_in), 0);
    check("len0_idle", longint'(busy), 0);

    issue_hold = 5;
    run_job(2, -1, "stall");
    issue_hold = -1;

    // Abort mid-job in the wait for pair 2, then offer a stale result.
    run_job(4, 1, "abort");
    check("abort_busy", longint'(busy), 0);
    check("abort_resrdy", longint'(mul_res_rdy), 0);
    check("abort_acc", sx(acc_re) | sx(acc_im), 0);
    mul_res_val = 1'b1; mul_res_re = 16'h1234; mul_res_im = 16'h0042;
    repeat (3) begin
      @(negedge clk);
      check("late_resrdy", longint'(mul_res_rdy), 0);
      check("late_busy", longint'(busy), 0);
    end
    mul_res_val = 1'b0;
    check("late_acc", sx(acc_re) | sx(acc_im), 0);
    run_job(1, -1, "after_abort");

    run_job(15, -1, "maxlen");
    for (int i = 0; i < 8; i++) run_job(int'($urandom_range(1, 15)), -1, "rand");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/complex_mult_master.md
COMPLEX_MULT_MASTER -- requirements
Module: complex_mult_master

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4; width of the dot-product length and the element counter.
REQ-002 The block SHALL have parameter ACC_W, default 24; width of each accumulator component, signed, ACC_W >= 17.
REQ-003 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port sw_rst  input  1  synchronous clear, same effect as rstn.
REQ-006 The block SHALL have port start  input  1  begin a job, sampled only in IDLE.
REQ-007 The block SHALL have port len  input  CNT_W  number of operand pairs in the job, sampled with start.
REQ-008 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 The block SHALL have ports in_val input 1 / in_rdy output 1; upstream operand handshake.
REQ-010 The block SHALL have ports in_a_re, in_a_im, in_b_re, in_b_im  input  8 each  upstream operand pair.
REQ-011 The block SHALL have ports mul_op_val output 1 / mul_op_rdy input 1; operand handshake to the multiplier.
REQ-012 The block SHALL have ports mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im  output  8 each  registered operands to the multiplier.
REQ-013 The block SHALL have ports mul_res_val input 1 / mul_res_rdy output 1; result handshake from the multiplier.
REQ-014 The block SHALL have ports mul_res_re, mul_res_im  input  16 each  multiplier result, two's complement.
REQ-015 The block SHALL have ports acc_val output 1 / acc_rdy input 1 / acc_re, acc_im output ACC_W each; final dot-product result.

Function
REQ-016 States SHALL be IDLE, LOAD, ISSUE, WAIT, DONE; one multiplier transaction in flight at most.
REQ-017 IDLE: start=1 and len=0 -> DONE with zero accumulators; start=1 and len>0 -> LOAD, latch len, clear accumulators and counter; start outside IDLE ignored.
REQ-018 LOAD: in_rdy=1; on in_val=1 capture the four operands into the mul_op_* registers -> ISSUE.
REQ-019 ISSUE: mul_op_val=1, operands held stable; on mul_op_rdy=1 -> WAIT.
REQ-020 WAIT: mul_res_rdy=1; on mul_res_val=1, sign-extend both results to ACC_W, add to acc_re/acc_im, increment counter; counter+1 == len -> DONE, else -> LOAD.
REQ-021 DONE: acc_val=1, acc_re/acc_im stable; on acc_rdy=1 -> IDLE; a start in the same cycle SHALL be ignored.
REQ-022 in_rdy, mul_op_val, mul_res_rdy, acc_val SHALL be asserted only in LOAD, ISSUE, WAIT, DONE respectively; all other handshakes low.
REQ-023 Minimum per-pair cost SHALL be 3 cycles (LOAD, ISSUE, WAIT) plus multiplier latency.
REQ-024 Counter SHALL be CNT_W bits; len = 2^CNT_W-1 SHALL complete without wrap.
REQ-025 Accumulation without saturation SHALL wrap modulo 2^ACC_W.

Reset
REQ-026 rstn low or sw_rst high SHALL force IDLE, zero accumulators, counter, operand registers, and all outputs (busy, in_rdy, mul_op_val, mul_res_rdy, acc_val = 0).
REQ-027 sw_rst mid-job SHALL abandon the job; a result arriving later in IDLE SHALL be ignored (mul_res_rdy=0).

Configuration
REQ-028 Macro COMPLEX_MULT_MASTER_SAT_EN defined: each accumulator add SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] per component; undefined: wrap per REQ-025.

Verification
REQ-029 start, len=1, pair (1+2j)(3+4j), model multiplier returns re=-5 (0xFFFB), im=10 -> acc_re=-5, acc_im=10, acc_val high until acc_rdy.
REQ-030 start, len=3, pairs each returning (100,-50) -> acc_re=300, acc_im=-150, exactly 3 mul_op_val handshakes.
REQ-031 start, len=0 -> DONE next cycle, acc_re=acc_im=0, no in_rdy or mul_op_val pulses.
REQ-032 mul_op_rdy held low 5 cycles in ISSUE -> mul_op_* stable, mul_op_val high throughout, in_rdy low.
REQ-033 sw_rst asserted in WAIT of pair 2 of len=4 -> IDLE next cycle, busy=0, late mul_res_val ignored, new job of len=1 gives correct sum.
REQ-034 ACC_W=17, len=3, each result 0x7FFF -> 0x17FFD mod 2^17 (wrap) without macro, 65535 with COMPLEX_MULT_MASTER_SAT_EN.
